fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequencer and single-port arbiter for the processor's byte-wide RAM. It owns the instruction pointer and fetches 16-bit instructions as two consecutive bytes, big-endian: high byte at `ip`, low byte at `ip+1`. Each instruction is presented to the decoder through a one-entry valid/ready buffer. Data load/store requests from the execution datapath share the same RAM port, and branches redirect the fetch stream.

## Interface
Parameters:
- `ADDR_BITS`, 8, RAM address width and instruction-pointer width.
- `DATA_BITS`, 8, RAM data width. The instruction is `2*DATA_BITS` wide.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  ADDR_BITS  RAM address.
- `mem_rd_en`  out  1  RAM read strobe. Read data appears on `mem_rdata` in the next cycle.
- `mem_wr_en`  out  1  RAM write strobe. The write commits at the same posedge.
- `mem_wdata`  out  DATA_BITS  RAM write data.
- `mem_rdata`  in  DATA_BITS  RAM read data, one cycle after `mem_rd_en`.
- `ir`  out  2*DATA_BITS  fetched instruction.
- `ir_addr`  out  ADDR_BITS  address of the high byte of `ir`.
- `ir_valid`  out  1  `ir` holds an unconsumed instruction.
- `ir_ready`  in  1  decoder accepts `ir`. The transfer happens when `ir_valid & ir_ready`.
- `redirect_en`  in  1  single-cycle branch request.
- `redirect_addr`  in  ADDR_BITS  branch target.
- `halt`  in  1  level signal that inhibits new fetches.
- `data_req`, `data_we`  in  1  data access request, and write (1) or read (0).
- `data_addr`  in  ADDR_BITS; `data_wdata`  in  DATA_BITS  data access address and write data.
- `data_gnt`  out  1  combinational pulse. The access is issued this cycle.
- `data_rdata`  out  DATA_BITS; `data_rvalid`  out  1  load result and a one-cycle valid pulse.

## Operation
- **States:** IDLE, FETCH_LO, FETCH_CAP, DATA_RD.
- **Memory outputs:** combinational from state and inputs. Outside the cases below, `mem_rd_en = mem_wr_en = data_gnt = 0`, `mem_addr = ip`, `mem_wdata = 0`.
- **IDLE, data request pending:** a data access wins whenever `data_req` = 1.
  - Drive `mem_addr = data_addr`, `mem_wr_en = data_we`, `mem_rd_en = !data_we`, `mem_wdata = data_wdata`, `data_gnt = 1`.
  - Next state is DATA_RD for a read, IDLE for a write.
- **IDLE, fetch start:** otherwise, if `!halt & !ir_valid`:
  - Drive `mem_addr = ip`, `mem_rd_en = 1`.
  - Next state is FETCH_LO.
- **IDLE, no action:** otherwise remain in IDLE with the port idle.
- **FETCH_LO:**
  - Drive `mem_addr = ip+1` (mod 2^ADDR_BITS), `mem_rd_en = 1`.
  - Latch the high byte from `mem_rdata`.
  - Next state is FETCH_CAP.
- **FETCH_CAP:**
  - `ir <= {hi, mem_rdata}`, `ir_addr <= ip`, `ip <= ip+2` (mod), `ir_valid <= 1`.
  - Next state is IDLE.
- **DATA_RD:**
  - `data_rdata <= mem_rdata`, `data_rvalid <= 1` for exactly one cycle.
  - Next state is IDLE.
  - No new grant is given in this state.
- **Consume:** `ir_valid & ir_ready` clears `ir_valid` at the edge. `ir` holds its value.
- **Redirect:** `redirect_en` has priority over everything except reset.
  - `ip <= redirect_addr` and `ir_valid <= 0`.
  - In FETCH_LO or FETCH_CAP, the fetch is aborted: `ir`, `ir_addr` and `ir_valid` are not updated, and the next state is IDLE. The `mem_rd_en` of the aborted FETCH_LO cycle is still driven.
  - In DATA_RD, the load completes normally.
  - In IDLE, the grant or fetch decision for that cycle still happens. A fetch started in that cycle is the wrong-path fetch and is aborted on the next cycle via a flag.
- **Halt:** blocks only fetch starts in IDLE. An in-flight fetch completes. Data accesses are still served.
- **Wrap-around:**
  - At `ip = 2^ADDR_BITS-1`, the high byte is read from the top address, the low byte from 0, and `ip` becomes 1.
  - `ip + 2` wraps silently.

## Timing
- **Reset (asynchronous, takes effect immediately):**
  - Registers: state = IDLE, `ip = 0`, `ir = 0`, `ir_addr = 0`, `ir_valid = 0`, `data_rvalid = 0`, `data_rdata = 0`.
  - While reset is high: `mem_rd_en = mem_wr_en = data_gnt = 0`.
  - Reset mid-fetch or mid-load discards that operation.
- **Fetch:** issue in cycle T, low-byte issue in T+1, capture in T+2, `ir_valid` high from T+3.
- **Throughput:** one instruction per 4 cycles with `ir_ready` held at 1 and no data traffic.
- **Load:** `data_gnt` in T, `data_rvalid` and `data_rdata` valid in T+2. A store commits at the end of T.
- **Requesters:** a requester holds `data_req` and its operands until it sees `data_gnt`. Back-to-back stores can be granted every cycle.
- **Simultaneous `data_req` and fetch start:** the data access wins, and the fetch starts at the next free IDLE cycle.

## Test plan
- **Sequential fetch:** RAM[0..3] = 12,34,56,78, reset, `ir_ready` = 1 -> `ir` = 0x1234 with `ir_addr` 0 at cycle 3, then `ir` = 0x5678 with `ir_addr` 2 at cycle 7. `mem_rd_en` is high in exactly two of every four cycles.
- **Backpressure:** `ir_ready` = 0 for 10 cycles -> `ir_valid` stays 1 with `ir` stable, and no `mem_rd_en` while full. Raising `ir_ready` produces the next fetch issue the cycle after the consume.
- **Data priority:** `data_req` read of 0x80 (RAM = 0xA5) asserted in the same IDLE cycle as a fetch start -> `data_gnt` = 1, and `data_rvalid` with `data_rdata` 0xA5 two cycles later. The fetch starts after that. A store of 0x3C to 0x81 reads back as 0x3C.
- **Redirect mid-fetch:** `redirect_en` to 0x40 during FETCH_LO -> the stale instruction is never made valid. The next `ir_addr` is 0x40 with the bytes at 0x40/0x41.
- **Wrap:** `redirect_addr` 0xFF, RAM[0xFF] = 0xDE, RAM[0] = 0xAD -> `ir` = 0xDEAD, `ir_addr` 0xFF, next `ir_addr` 0x01.
- **Halt and reset:** `halt` = 1 blocks fetches while data requests are still granted. Asserting `reset` in FETCH_CAP clears all outputs to their reset values immediately.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Bundle of the RAM port, instruction buffer and data-access signals of fetch_controller.
// master = the controller, slave = RAM, decoder and execution datapath.
interface fetch_controller_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [ADDR_BITS-1:0]   mem_addr;
  logic                   mem_rd_en;
  logic                   mem_wr_en;
  logic [DATA_BITS-1:0]   mem_wdata;
  logic [DATA_BITS-1:0]   mem_rdata;

  // ir_valid/ir_ready: ir_valid rises only when ir holds a complete instruction;
  // a transfer happens on each edge with ir_valid & ir_ready; ir, ir_addr hold while valid.
  logic [2*DATA_BITS-1:0] ir;
  logic [ADDR_BITS-1:0]   ir_addr;
  logic                   ir_valid;
  logic                   ir_ready;

  logic                   redirect_en;
  logic [ADDR_BITS-1:0]   redirect_addr;
  logic                   halt;

  logic                   data_req;
  logic                   data_we;
  logic [ADDR_BITS-1:0]   data_addr;
  logic [DATA_BITS-1:0]   data_wdata;
  logic                   data_gnt;
  logic [DATA_BITS-1:0]   data_rdata;
  logic                   data_rvalid;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output ir, ir_addr, ir_valid,
    output data_gnt, data_rdata, data_rvalid,
    input  mem_rdata, ir_ready, redirect_en, redirect_addr, halt,
    input  data_req, data_we, data_addr, data_wdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  ir, ir_addr, ir_valid,
    input  data_gnt, data_rdata, data_rvalid,
    output mem_rdata, ir_ready, redirect_en, redirect_addr, halt,
    output data_req, data_we, data_addr, data_wdata
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer and single-port RAM arbiter: 16-bit big-endian
// instructions fetched as two bytes, with data loads/stores taking priority.
module fetch_controller #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  fetch_controller_if.master bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_LO  = 2'd1,
    FETCH_CAP = 2'd2,
    DATA_RD   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_BITS-1:0]   r_ip;
  logic [DATA_BITS-1:0]   r_hi;
  logic [2*DATA_BITS-1:0] r_ir;
  logic [ADDR_BITS-1:0]   r_ir_addr;
  logic                   r_ir_valid;
  logic [DATA_BITS-1:0]   r_rdata;
  logic                   r_rvalid;
  logic                   r_abort;

  logic [ADDR_BITS-1:0]   w_mem_addr;
  logic                   w_rd_en;
  logic                   w_wr_en;
  logic [DATA_BITS-1:0]   w_wdata;
  logic                   w_gnt;
  logic                   w_fetch_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_mem_addr    = r_ip;
    w_rd_en       = 1'b0;
    w_wr_en       = 1'b0;
    w_wdata       = '0;
    w_gnt         = 1'b0;
    w_fetch_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.data_req) begin
          w_mem_addr = bus.data_addr;
          w_wr_en    = bus.data_we;
          w_rd_en    = !bus.data_we;
          w_wdata    = bus.data_wdata;
          w_gnt      = 1'b1;
          w_next     = bus.data_we ? IDLE : DATA_RD;
        end else if (!bus.halt && !r_ir_valid) begin
          w_rd_en       = 1'b1;
          w_fetch_start = 1'b1;
          w_next        = FETCH_LO;
        end
      end
      FETCH_LO: begin
        // The low-byte read is still issued when this fetch is being thrown away.
        w_mem_addr = r_ip + ADDR_BITS'(1);
        w_rd_en    = 1'b1;
        w_next     = (bus.redirect_en || r_abort) ? IDLE : FETCH_CAP;
      end
      FETCH_CAP: w_next = IDLE;
      DATA_RD:   w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    if (reset) begin
      w_rd_en = 1'b0;
      w_wr_en = 1'b0;
      w_gnt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ip       <= '0;
      r_hi       <= '0;
      r_ir       <= '0;
      r_ir_addr  <= '0;
      r_ir_valid <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      // A fetch launched in the same cycle as a branch is on the wrong path.
      r_abort  <= w_fetch_start && bus.redirect_en;
      r_rvalid <= (r_state == DATA_RD);
      if (r_state == DATA_RD)  r_rdata <= bus.mem_rdata;
      if (r_state == FETCH_LO) r_hi    <= bus.mem_rdata;
      if (bus.redirect_en) begin
        r_ip       <= bus.redirect_addr;
        r_ir_valid <= 1'b0;
      end else if (r_state == FETCH_CAP) begin
        r_ir       <= {r_hi, bus.mem_rdata};
        r_ir_addr  <= r_ip;
        r_ip       <= r_ip + ADDR_BITS'(2);
        r_ir_valid <= 1'b1;
      end else if (r_ir_valid && bus.ir_ready) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_wr_en   = w_wr_en;
  assign bus.mem_wdata   = w_wdata;
  assign bus.data_gnt    = w_gnt;
  assign bus.ir          = r_ir;
  assign bus.ir_addr     = r_ir_addr;
  assign bus.ir_valid    = r_ir_valid;
  assign bus.data_rdata  = r_rdata;
  assign bus.data_rvalid = r_rvalid;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized checks of fetch_controller against a byte-RAM model
// and an instruction-stream / load-result reference.
module tb_fetch_controller;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int N_RAND = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  fetch_controller_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  fetch_controller #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // RAM model: write commits at the edge, read data one cycle after the strobe.
  logic [DW-1:0] ram [256];
  logic [DW-1:0] img [256];
  logic [DW-1:0] mram [256];
  logic          load_img;
  logic [DW-1:0] rdata_q;

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 256; i++) ram[i] <= img[i];
    end else if (bus.mem_wr_en) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd_en) rdata_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  int            n_pass;
  int            n_checks;
  logic [DW-1:0] exp_q [$];
  int            due_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2*DW-1:0] instr_at(input logic [AW-1:0] a);
    logic [AW-1:0] a1;
    a1 = a + 8'd1;
    return {mram[a], mram[a1]};
  endfunction

  // Presents one data request in an IDLE cycle and checks it is granted at once.
  task automatic issue_data(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.data_req   = 1'b1;
    bus.data_we    = we;
    bus.data_addr  = addr;
    bus.data_wdata = wd;
    #1;
    chk("gnt", bus.data_gnt, 1);
    chk("gnt_addr", bus.mem_addr, addr);
    chk("gnt_wr_en", bus.mem_wr_en, we);
    chk("gnt_rd_en", bus.mem_rd_en, !we);
    chk("gnt_wdata", bus.mem_wdata, wd);
    if (we) mram[addr] = wd;
    tick();
    bus.data_req = 1'b0;
  endtask

  // Called in the cycle after a read grant; leaves time in the result cycle.
  task automatic expect_load(input logic [DW-1:0] v);
    #1;
    chk("load_rvalid_early", bus.data_rvalid, 0);
    chk("load_no_port_use", bus.mem_rd_en, 0);
    tick();
    chk("load_rvalid", bus.data_rvalid, 1);
    chk("load_rdata", bus.data_rdata, v);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!bus.ir_valid && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, bus.ir_valid, 1);
  endtask

  task automatic check_rvalid(input int cyc);
    if (bus.data_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rnd_extra_rvalid", bus.data_rvalid, 0);
      end else begin
        chk("rnd_rdata", bus.data_rdata, exp_q.pop_front());
        chk("rnd_load_latency", cyc, due_q.pop_front());
      end
    end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
      chk("rnd_missing_rvalid", bus.data_rvalid, 1);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] exp_ip;
    int            pend;
    int            pwait;
    int            n_instr;

    n_pass = 0;
    n_checks = 0;
    reset = 1'b1;
    load_img = 1'b0;
    bus.ir_ready = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_addr = '0;
    bus.halt = 1'b0;
    bus.data_req = 1'b0;
    bus.data_we = 1'b0;
    bus.data_addr = '0;
    bus.data_wdata = '0;
    for (int i = 0; i < 256; i++) img[i] = DW'($urandom_range(0, 255));
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78;
    img[8'h80] = 8'hA5;
    for (int i = 0; i < 256; i++) mram[i] = img[i];

    // Reset state, with a data request pending to prove the grant is masked.
    load_img = 1'b1;
    bus.data_req = 1'b1;
    bus.data_addr = 8'h80;
    tick();
    load_img = 1'b0;
    #1;
    chk("rst_gnt", bus.data_gnt, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_ir", bus.ir, 0);
    chk("rst_ir_addr", bus.ir_addr, 0);
    chk("rst_ir_valid", bus.ir_valid, 0);
    chk("rst_rvalid", bus.data_rvalid, 0);
    chk("rst_state", dbg_state, 0);
    bus.data_req = 1'b0;
    tick();

    // Sequential fetch: one instruction per four cycles.
    bus.ir_ready = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("seq_rd_en", bus.mem_rd_en, (c % 4) < 2);
      if (c % 4 == 0) chk("seq_issue_addr", bus.mem_addr, c / 2);
      if (c == 3) begin
        chk("seq_ir0", bus.ir, 16'h1234);
        chk("seq_ir0_addr", bus.ir_addr, 0);
        chk("seq_ir0_valid", bus.ir_valid, 1);
      end
      if (c == 7) begin
        chk("seq_ir1", bus.ir, 16'h5678);
        chk("seq_ir1_addr", bus.ir_addr, 2);
      end
      tick();
    end

    // Backpressure: buffer full for 10 cycles, no reads, then refetch right after consume.
    bus.ir_ready = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", bus.ir_valid, 1);
      chk("bp_ir", bus.ir, instr_at(8'd4));
      chk("bp_no_rd", bus.mem_rd_en, 0);
      tick();
    end
    bus.ir_ready = 1'b1;
    #1;
    chk("bp_no_rd_consume", bus.mem_rd_en, 0);
    tick();
    chk("bp_refetch_rd", bus.mem_rd_en, 1);
    chk("bp_refetch_addr", bus.mem_addr, 6);
    tick(); tick(); tick();
    chk("bp_ir_next", bus.ir, instr_at(8'd6));
    tick();

    // Data read wins over a simultaneous fetch start.
    issue_data(1'b0, 8'h80, 8'h00);
    expect_load(8'hA5);
    #1;
    chk("dp_fetch_after_rd", bus.mem_rd_en, 1);
    chk("dp_fetch_after_addr", bus.mem_addr, 8);
    bus.ir_ready = 1'b0;
    tick();
    chk("dp_rvalid_pulse", bus.data_rvalid, 0);
    wait_valid(4, "dp_fetch");
    chk("dp_ir", bus.ir, instr_at(8'd8));
    issue_data(1'b1, 8'h81, 8'h3C);
    issue_data(1'b1, 8'h82, 8'h5A);
    issue_data(1'b0, 8'h81, 8'h00);
    expect_load(8'h3C);
    tick();
    issue_data(1'b0, 8'h82, 8'h00);
    expect_load(8'h5A);

    // Redirect during FETCH_LO discards the in-flight fetch.
    bus.ir_ready = 1'b1;
    tick();
    chk("rd_fetch_rd", bus.mem_rd_en, 1);
    chk("rd_fetch_addr", bus.mem_addr, 8'h0A);
    tick();
    bus.redirect_en = 1'b1;
    bus.redirect_addr = 8'h40;
    #1;
    chk("rd_lo_state", dbg_state, 1);
    chk("rd_lo_rd_en", bus.mem_rd_en, 1);
    tick();
    bus.redirect_en = 1'b0;
    #1;
    chk("rd_new_rd", bus.mem_rd_en, 1);
    chk("rd_new_addr", bus.mem_addr, 8'h40);
    chk("rd_no_stale", bus.ir_valid, 0);
    wait_valid(8, "rd_target");
    chk("rd_ir_addr", bus.ir_addr, 8'h40);
    chk("rd_ir", bus.ir, instr_at(8'h40));

    // Redirect in the IDLE cycle of a fetch start: that fetch is wrong-path.
    tick();
    bus.redirect_en = 1'b1;
    bus.redirect_addr = 8'h50;
    #1;
    chk("ri_start_rd", bus.mem_rd_en, 1);
    chk("ri_start_addr", bus.mem_addr, 8'h42);
    tick();
    bus.redirect_en = 1'b0;
    #1;
    chk("ri_lo_rd", bus.mem_rd_en, 1);
    tick();
    chk("ri_idle_state", dbg_state, 0);
    chk("ri_new_addr", bus.mem_addr, 8'h50);
    wait_valid(8, "ri_target");
    chk("ri_ir_addr", bus.ir_addr, 8'h50);
    chk("ri_ir", bus.ir, instr_at(8'h50));

    // Halt blocks fetch starts but data accesses are still granted.
    bus.halt = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("halt_no_rd", bus.mem_rd_en, 0);
      chk("halt_empty", bus.ir_valid, 0);
      tick();
    end
    issue_data(1'b1, 8'hFF, 8'hDE);
    issue_data(1'b1, 8'h00, 8'hAD);
    bus.redirect_en = 1'b1;
    bus.redirect_addr = 8'hFF;
    #1;
    chk("halt_redirect_no_rd", bus.mem_rd_en, 0);
    tick();
    bus.redirect_en = 1'b0;
    bus.halt = 1'b0;
    #1;
    chk("wrap_issue_rd", bus.mem_rd_en, 1);
    chk("wrap_issue_addr", bus.mem_addr, 8'hFF);

    // Wrap at the top of the address space.
    wait_valid(8, "wrap");
    chk("wrap_ir", bus.ir, 16'hDEAD);
    chk("wrap_ir_addr", bus.ir_addr, 8'hFF);
    tick();
    wait_valid(8, "wrap_next");
    chk("wrap_next_addr", bus.ir_addr, 8'h01);
    chk("wrap_next_ir", bus.ir, instr_at(8'h01));

    // Asynchronous reset in FETCH_CAP.
    tick();
    for (int n = 0; n < 6 && dbg_state != 2'd2; n++) tick();
    chk("rc_in_cap", dbg_state, 2);
    reset = 1'b1;
    bus.data_req = 1'b1;
    bus.data_we = 1'b0;
    #1;
    chk("rc_ir", bus.ir, 0);
    chk("rc_ir_addr", bus.ir_addr, 0);
    chk("rc_ir_valid", bus.ir_valid, 0);
    chk("rc_rdata", bus.data_rdata, 0);
    chk("rc_rvalid", bus.data_rvalid, 0);
    chk("rc_rd_en", bus.mem_rd_en, 0);
    chk("rc_gnt", bus.data_gnt, 0);
    chk("rc_state", dbg_state, 0);
    tick();
    bus.data_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rc_restart_addr", bus.mem_addr, 0);
    chk("rc_restart_rd", bus.mem_rd_en, 1);

    // Randomized traffic against the instruction-stream and load reference.
    exp_ip = '0;
    pend = 0;
    pwait = 0;
    n_instr = 0;
    for (int cyc = 0; cyc < N_RAND; cyc++) begin
      bus.ir_ready = 1'($urandom_range(0, 1));
      bus.halt = ($urandom_range(0, 9) == 0);
      if (pend == 0 && $urandom_range(0, 3) == 0) begin
        pend = 1;
        pwait = 0;
        bus.data_we = 1'($urandom_range(0, 1));
        bus.data_addr = AW'(8'hE0 + $urandom_range(0, 31));
        bus.data_wdata = DW'($urandom_range(0, 255));
      end
      bus.data_req = (pend != 0);
      #1;
      check_rvalid(cyc);
      if (bus.data_gnt) begin
        chk("rnd_gnt_has_req", pend, 1);
        chk("rnd_gnt_addr", bus.mem_addr, bus.data_addr);
        chk("rnd_gnt_wait", pwait <= 3, 1);
        if (bus.data_we) begin
          mram[bus.data_addr] = bus.data_wdata;
        end else begin
          exp_q.push_back(mram[bus.data_addr]);
          due_q.push_back(cyc + 2);
        end
        pend = 0;
      end else if (pend != 0) begin
        pwait++;
      end
      if (bus.ir_valid && bus.ir_ready) begin
        chk("rnd_ir", bus.ir, instr_at(exp_ip));
        chk("rnd_ir_addr", bus.ir_addr, exp_ip);
        exp_ip = exp_ip + 8'd2;
        n_instr++;
      end
      tick();
    end
    bus.data_req = 1'b0;
    bus.halt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_rvalid(N_RAND + k);
      tick();
    end
    chk("rnd_loads_drained", due_q.size(), 0);
    chk("rnd_progress", n_instr > 15, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
